// File: rtl/act_cas_sched.sv
// ACT/CAS command scheduler with a countdown FIFO feeding a data-phase burst engine.
// Define SCHED_STATS_EN to build the act/read/write statistics counters; otherwise they read as zero.
module act_cas_sched #(
    parameter int DEPTH = 4
) (
    input  logic        clock_t,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_rw,
    output logic        req_ready,
    input  logic [4:0]  cfg_trcd,
    input  logic [5:0]  cfg_rd_delay,
    input  logic [5:0]  cfg_wr_delay,
    input  logic [3:0]  cfg_bl,
    input  logic [3:0]  cfg_tccd,
    output logic        act_rdy,
    output logic        cas_rdy,
    output logic        rw_rdy,
    output logic [1:0]  rw_dir,
    output logic        late_err,
    output logic [15:0] act_cnt,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
);

    // state | meaning
    // IDLE  | waiting for a request; req_ready may be high
    // ACT   | act_rdy strobe; tRCD counter loaded
    // TRCD  | counting down ACT-to-CAS delay
    // CAS   | cas_rdy strobe; entry already pushed on the way in
    typedef enum logic [1:0] {IDLE, ACT, TRCD, CAS} state_t;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t        state, state_nxt;
    logic [1:0]    cmd_rw;
    logic [4:0]    trcd_cnt;
    logic [4:0]    trcd_ld;
    logic [3:0]    tccd_cnt;
    logic [1:0]    ent_rw  [DEPTH];
    logic [5:0]    ent_cnt [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   fifo_cnt;
    logic [2:0]    beat_cnt;
    logic [1:0]    cur_dir;
    logic          fifo_full, accept, rw_legal, push, pop, head_due;
    logic [5:0]    push_dly;
    logic [2:0]    bl_beats;

    assign fifo_full = (fifo_cnt == (AW+1)'(DEPTH));
    assign req_ready = !reset && (state == IDLE) && !fifo_full && (tccd_cnt == 4'd0);
    assign accept    = req_valid && req_ready;
    assign rw_legal  = (req_rw == 2'b01) || (req_rw == 2'b10);
    assign trcd_ld   = (cfg_trcd == 5'd0) ? 5'd0 : cfg_trcd - 5'd1;

    always_comb begin
        push_dly = 6'd0;
        if (cmd_rw == 2'b10)
            push_dly = (cfg_wr_delay == 6'd0) ? 6'd0 : cfg_wr_delay - 6'd1;
        else
            push_dly = (cfg_rd_delay == 6'd0) ? 6'd0 : cfg_rd_delay - 6'd1;
    end

    assign head_due = (fifo_cnt != '0) && (ent_cnt[rd_ptr] == 6'd0);
    // A due head may start on the last beat of the running burst, giving back-to-back phases.
    assign pop      = head_due && (beat_cnt <= 3'd1);
    assign bl_beats = (cfg_bl == 4'd4) ? 3'd2 : 3'd4;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: if (accept && rw_legal) state_nxt = ACT;
            ACT: begin
                if (trcd_ld == 5'd0) begin
                    state_nxt = CAS;
                    push      = 1'b1;
                end else begin
                    state_nxt = TRCD;
                end
            end
            TRCD: begin
                if (trcd_cnt <= 5'd1) begin
                    state_nxt = CAS;
                    push      = 1'b1;
                end
            end
            CAS:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_t) begin
        if (reset) begin
            state    <= IDLE;
            cmd_rw   <= 2'b00;
            trcd_cnt <= 5'd0;
            tccd_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept && rw_legal) cmd_rw <= req_rw;
            if (state == ACT)
                trcd_cnt <= trcd_ld;
            else if (trcd_cnt != 5'd0)
                trcd_cnt <= trcd_cnt - 5'd1;
            if (push)
                tccd_cnt <= cfg_tccd;
            else if (tccd_cnt != 4'd0)
                tccd_cnt <= tccd_cnt - 4'd1;
        end
    end

    always_ff @(posedge clock_t) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rw[i]  <= 2'b00;
                ent_cnt[i] <= 6'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (ent_cnt[i] != 6'd0) ent_cnt[i] <= ent_cnt[i] - 6'd1;
            if (push) begin
                ent_rw[wr_ptr]  <= cmd_rw;
                ent_cnt[wr_ptr] <= push_dly;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clock_t) begin
        if (reset) begin
            beat_cnt <= 3'd0;
            cur_dir  <= 2'b00;
            late_err <= 1'b0;
        end else begin
            if (pop) begin
                beat_cnt <= bl_beats;
                cur_dir  <= ent_rw[rd_ptr];
            end else if (beat_cnt != 3'd0) begin
                beat_cnt <= beat_cnt - 3'd1;
            end
            if (head_due && (beat_cnt > 3'd1)) late_err <= 1'b1;
        end
    end

    assign act_rdy = (state == ACT);
    assign cas_rdy = (state == CAS);
    assign rw_rdy  = (beat_cnt != 3'd0);
    assign rw_dir  = rw_rdy ? cur_dir : 2'b00;

`ifdef SCHED_STATS_EN
    always_ff @(posedge clock_t) begin
        if (reset) begin
            act_cnt <= 16'd0;
            rd_cnt  <= 16'd0;
            wr_cnt  <= 16'd0;
        end else begin
            if (state == ACT) act_cnt <= act_cnt + 16'd1;
            if (pop && (ent_rw[rd_ptr] == 2'b01)) rd_cnt <= rd_cnt + 16'd1;
            if (pop && (ent_rw[rd_ptr] == 2'b10)) wr_cnt <= wr_cnt + 16'd1;
        end
    end
`else
    assign act_cnt = 16'd0;
    assign rd_cnt  = 16'd0;
    assign wr_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_act_cas_sched.sv
// Randomized and directed bench for act_cas_sched against a cycle-stamped transaction model.
module tb_act_cas_sched;
    localparam int DEPTH = 4;

    logic        clock_t = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_rw = 2'b00;
    logic        req_ready;
    logic [4:0]  cfg_trcd = 5'd4;
    logic [5:0]  cfg_rd_delay = 6'd11;
    logic [5:0]  cfg_wr_delay = 6'd9;
    logic [3:0]  cfg_bl = 4'd8;
    logic [3:0]  cfg_tccd = 4'd0;
    logic        act_rdy, cas_rdy, rw_rdy, late_err;
    logic [1:0]  rw_dir;
    logic [15:0] act_cnt, rd_cnt, wr_cnt;

    act_cas_sched #(.DEPTH(DEPTH)) dut (
        .clock_t(clock_t), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
        .req_ready(req_ready), .cfg_trcd(cfg_trcd), .cfg_rd_delay(cfg_rd_delay),
        .cfg_wr_delay(cfg_wr_delay), .cfg_bl(cfg_bl), .cfg_tccd(cfg_tccd),
        .act_rdy(act_rdy), .cas_rdy(cas_rdy), .rw_rdy(rw_rdy), .rw_dir(rw_dir),
        .late_err(late_err), .act_cnt(act_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clock_t = ~clock_t;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // One record per legal request, stamped with the cycles at which each event must happen.
    typedef struct {
        int act; int cas; int due; int start; int len; int late_vis; logic [1:0] dir;
    } ent_t;
    ent_t q[$];
    int cas_last, tccd_last, last_end, last_start;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic void model_clear();
        q.delete();
        cas_last = -1000; tccd_last = 0; last_end = -1000; last_start = -1000;
    endfunction

    function automatic logic exp_ready(input int t);
        int pend = 0;
        if (t <= cas_last) return 1'b0;
        if (t < cas_last + tccd_last) return 1'b0;
        foreach (q[i]) if (q[i].cas <= t && t < q[i].start) pend++;
        return (pend < DEPTH);
    endfunction

    function automatic void model_accept(input int t, input logic [1:0] rw);
        ent_t e;
        int d;
        if (!(rw == 2'b01 || rw == 2'b10)) return;
        e.act = t + 1;
        e.cas = t + 1 + imax(int'(cfg_trcd), 1);
        d = imax((rw == 2'b01) ? int'(cfg_rd_delay) : int'(cfg_wr_delay), 1);
        e.due = e.cas + d;
        e.len = (cfg_bl == 4'd4) ? 2 : 4;
        e.start = imax(e.due, last_end + 1);
        e.late_vis = (e.start > e.due) ? imax(e.due - 1, last_start) + 1 : (1 << 30);
        e.dir = rw;
        last_end = e.start + e.len - 1;
        last_start = e.start;
        cas_last = e.cas;
        tccd_last = int'(cfg_tccd);
        q.push_back(e);
    endfunction

    task automatic check_outputs();
        int t = cyc;
        logic e_rdy, e_act, e_cas, e_rw, e_late;
        logic [1:0] e_dir;
        int e_ac = 0, e_rc = 0, e_wc = 0;
        e_rdy = exp_ready(t);
        e_act = 1'b0; e_cas = 1'b0; e_rw = 1'b0; e_late = 1'b0; e_dir = 2'b00;
        foreach (q[i]) begin
            if (q[i].act == t) e_act = 1'b1;
            if (q[i].cas == t) e_cas = 1'b1;
            if (q[i].start <= t && t < q[i].start + q[i].len) begin
                e_rw = 1'b1; e_dir = q[i].dir;
            end
            if (q[i].late_vis <= t) e_late = 1'b1;
`ifdef SCHED_STATS_EN
            if (q[i].act < t) e_ac++;
            if (q[i].start <= t && q[i].dir == 2'b01) e_rc++;
            if (q[i].start <= t && q[i].dir == 2'b10) e_wc++;
`endif
        end
        n_checks++;
        if (req_ready !== e_rdy) begin n_fail++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", t, req_ready, e_rdy); end
        n_checks++;
        if (act_rdy !== e_act) begin n_fail++; $display("FAIL act_rdy cyc=%0d got=%b exp=%b", t, act_rdy, e_act); end
        n_checks++;
        if (cas_rdy !== e_cas) begin n_fail++; $display("FAIL cas_rdy cyc=%0d got=%b exp=%b", t, cas_rdy, e_cas); end
        n_checks++;
        if (rw_rdy !== e_rw) begin n_fail++; $display("FAIL rw_rdy cyc=%0d got=%b exp=%b", t, rw_rdy, e_rw); end
        n_checks++;
        if (rw_dir !== e_dir) begin n_fail++; $display("FAIL rw_dir cyc=%0d got=%b exp=%b", t, rw_dir, e_dir); end
        n_checks++;
        if (late_err !== e_late) begin n_fail++; $display("FAIL late_err cyc=%0d got=%b exp=%b", t, late_err, e_late); end
        n_checks++;
        if (act_cnt !== 16'(e_ac) || rd_cnt !== 16'(e_rc) || wr_cnt !== 16'(e_wc)) begin
            n_fail++;
            $display("FAIL stats cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", t, act_cnt, rd_cnt, wr_cnt, e_ac, e_rc, e_wc);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] rw, output logic acc);
        req_valid = v;
        req_rw = rw;
        @(negedge clock_t);
        check_outputs();
        acc = v && exp_ready(cyc);
        if (acc) model_accept(cyc, rw);
        @(posedge clock_t);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock_t);
            n_checks++;
            if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ready_in_reset cyc=%0d got=%b exp=0", cyc, req_ready); end
            @(posedge clock_t);
            cyc++;
            #1;
        end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic send(input logic [1:0] rw);
        logic acc = 1'b0;
        int budget = 0;
        while (!acc && budget < 300) begin
            step(1'b1, rw, acc);
            budget++;
        end
        req_valid = 1'b0;
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout cyc=%0d got=not_accepted exp=accepted", cyc);
        end
    endtask

    task automatic drain();
        logic acc;
        int budget = 0;
        while ((cyc <= last_end + 1 || cyc <= cas_last + tccd_last + 1) && budget < 500) begin
            step(1'b0, 2'b00, acc);
            budget++;
        end
        step(1'b0, 2'b00, acc);
        if (budget >= 500) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout cyc=%0d got=busy exp=idle", cyc);
        end
    endtask

    task automatic test_reset();
        logic acc;
        do_reset(3);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, acc);
    endtask

    task automatic test_single_read();
        do_reset(2);
        cfg_trcd = 5'd4; cfg_rd_delay = 6'd11; cfg_bl = 4'd8; cfg_tccd = 4'd0;
        send(2'b01);
        drain();
    endtask

    task automatic test_back_to_back();
        do_reset(2);
        cfg_trcd = 5'd2; cfg_wr_delay = 6'd9; cfg_bl = 4'd8; cfg_tccd = 4'd4;
        send(2'b10);
        send(2'b10);
        drain();
        n_checks++;
        if (late_err !== 1'b0) begin n_fail++; $display("FAIL b2b_late got=%b exp=0", late_err); end
    endtask

    task automatic test_collision();
        do_reset(2);
        cfg_trcd = 5'd1; cfg_rd_delay = 6'd3; cfg_bl = 4'd8; cfg_tccd = 4'd0;
        for (int i = 0; i < 3; i++) send(2'b01);
        drain();
        n_checks++;
        if (late_err !== 1'b1) begin n_fail++; $display("FAIL collision_late got=%b exp=1", late_err); end
    endtask

    task automatic test_full();
        do_reset(2);
        cfg_trcd = 5'd1; cfg_rd_delay = 6'd63; cfg_wr_delay = 6'd63; cfg_bl = 4'd4; cfg_tccd = 4'd0;
        for (int i = 0; i < 5; i++) send((i % 2 == 0) ? 2'b10 : 2'b01);
        drain();
    endtask

    task automatic test_illegal();
        logic acc;
        do_reset(2);
        cfg_trcd = 5'd2; cfg_rd_delay = 6'd4; cfg_bl = 4'd4; cfg_tccd = 4'd1;
        step(1'b1, 2'b00, acc);
        step(1'b1, 2'b11, acc);
        send(2'b01);
        drain();
    endtask

    task automatic test_stats();
        do_reset(2);
        cfg_trcd = 5'd2; cfg_rd_delay = 6'd5; cfg_wr_delay = 6'd4; cfg_bl = 4'd4; cfg_tccd = 4'd2;
        send(2'b01); send(2'b10); send(2'b01); send(2'b10); send(2'b01);
        drain();
        n_checks++;
`ifdef SCHED_STATS_EN
        if (act_cnt !== 16'd5 || rd_cnt !== 16'd3 || wr_cnt !== 16'd2) begin
            n_fail++; $display("FAIL stats_total got=%0d/%0d/%0d exp=5/3/2", act_cnt, rd_cnt, wr_cnt);
        end
`else
        if (act_cnt !== 16'd0 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
            n_fail++; $display("FAIL stats_total got=%0d/%0d/%0d exp=0/0/0", act_cnt, rd_cnt, wr_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic acc;
        logic [1:0] rw;
        int r;
        do_reset(2);
        for (int round = 0; round < 8; round++) begin
            cfg_trcd = 5'($urandom_range(0, 6));
            cfg_rd_delay = 6'($urandom_range(0, 20));
            cfg_wr_delay = 6'($urandom_range(0, 20));
            r = $urandom_range(0, 3);
            cfg_bl = (r == 0) ? 4'd4 : (r == 1) ? 4'd8 : (r == 2) ? 4'd5 : 4'd0;
            cfg_tccd = 4'($urandom_range(0, 6));
            for (int i = 0; i < 60; i++) begin
                r = $urandom_range(0, 7);
                rw = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : (r == 6) ? 2'b00 : 2'b11;
                step(1'($urandom_range(0, 1)), rw, acc);
            end
            drain();
        end
    endtask

    task automatic test_reset_mid_burst();
        logic acc;
        int tgt;
        int budget = 0;
        do_reset(2);
        cfg_trcd = 5'd2; cfg_rd_delay = 6'd5; cfg_bl = 4'd8; cfg_tccd = 4'd0;
        send(2'b01);
        send(2'b10);
        tgt = q[0].start + 1;
        while (cyc < tgt && budget < 100) begin
            step(1'b0, 2'b00, acc);
            budget++;
        end
        do_reset(1);
        for (int i = 0; i < 25; i++) step(1'b0, 2'b00, acc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_collision();
        test_full();
        test_illegal();
        test_stats();
        test_random();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/act_cas_sched.md
ACT_CAS_SCHED -- requirements
Module: act_cas_sched

Interface
REQ-001 Parameter DEPTH, default 4: pending data-phase FIFO entries (power of 2, 2..16).
REQ-002 clock_t  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  host request present.
REQ-005 req_rw  in  2  request direction; 2'b01 READ, 2'b10 WRITE; other codes illegal.
REQ-006 req_ready  out  1  scheduler can accept a request this cycle.
REQ-007 cfg_trcd  in  5  ACT-to-CAS delay in clocks.
REQ-008 cfg_rd_delay / cfg_wr_delay  in  6 each  CAS-to-data delay in clocks (CL+AL-RPRE / CWL+AL-WPRE).
REQ-009 cfg_bl  in  4  burst length, 4 or 8.
REQ-010 cfg_tccd  in  4  minimum CAS-to-CAS spacing in clocks.
REQ-011 act_rdy / cas_rdy  out  1 each  one-cycle command strobes to the burst data stage.
REQ-012 rw_rdy  out  1  data-phase strobe, high cfg_bl/2 consecutive cycles per burst.
REQ-013 rw_dir  out  2  direction of the active burst; 2'b00 when rw_rdy low.
REQ-014 late_err  out  1  sticky: a data phase started later than its delay.
REQ-015 act_cnt / rd_cnt / wr_cnt  out  16 each  statistics counters (see Configuration).

Function
REQ-016 Command FSM states: IDLE, ACT, TRCD, CAS.
REQ-017 Accept = req_valid & req_ready at an edge; captures req_rw; IDLE->ACT.
REQ-018 req_ready = (state==IDLE) & FIFO not full & tccd_cnt==0; purely combinational from registers.
REQ-019 ACT: act_rdy high exactly one cycle (cycle after accept); ACT->TRCD, load trcd_cnt = max(cfg_trcd,1)-1.
REQ-020 TRCD: decrement; at 0 -> CAS; cas_rdy therefore high max(cfg_trcd,1) cycles after act_rdy.
REQ-021 CAS: cas_rdy high one cycle; push {rw, max(delay,1)-1} into FIFO; load tccd_cnt = cfg_tccd; CAS->IDLE.
REQ-022 tccd_cnt decrements each cycle to 0, saturating.
REQ-023 Every FIFO entry's countdown decrements each cycle, saturating at 0.
REQ-024 Burst engine: when idle and head countdown==0, pop head; rw_rdy high starting next cycle for cfg_bl/2 cycles; rw_dir = entry rw.
REQ-025 Thus first rw_rdy cycle = cas_rdy cycle + max(delay,1), absent collision.
REQ-026 Collision: head reaches 0 while a burst is active -> starts the cycle after the current burst ends (back-to-back, no gap); late_err set.
REQ-027 Push and pop in the same cycle allowed; FIFO full blocks acceptance only (never overflows).
REQ-028 Illegal req_rw accepted but produces no ACT: FSM stays IDLE, request dropped.
REQ-029 cfg_* sampled at the point of use (ACT load, CAS push, burst start); changes mid-operation affect only later loads.
REQ-030 cfg_bl other than 4 or 8 treated as 8.

Reset
REQ-031 reset high at an edge: FSM->IDLE, FIFO emptied, all counters zero, burst aborted.
REQ-032 Reset values: req_ready 0 while reset high, 1 first cycle after; act_rdy, cas_rdy, rw_rdy, late_err 0; rw_dir 2'b00; act_cnt/rd_cnt/wr_cnt 0.
REQ-033 Reset mid-burst terminates rw_rdy the next cycle; no pending entry survives.

Configuration
REQ-034 Macro SCHED_STATS_EN: defined -> act_cnt +1 per act_rdy, rd_cnt/wr_cnt +1 per READ/WRITE burst start; 16-bit, wrap 0xFFFF->0.
REQ-035 Undefined -> counter logic absent; act_cnt/rd_cnt/wr_cnt tied to 0; all other behaviour identical.

Verification
REQ-036 Single READ, trcd=4, rd_delay=11, bl=8, accept at cycle 0 -> act_rdy cycle 1, cas_rdy cycle 5, rw_rdy cycles 16-19, rw_dir=01.
REQ-037 Two WRITEs back-to-back, trcd=2, wr_delay=9, bl=8, tccd=4 -> second accept blocked until tccd expires; bursts contiguous or gapped; late_err stays 0.
REQ-038 tccd=0, bl=8, trcd=1, delay=3, three requests -> bursts serialize back-to-back, late_err=1.
REQ-039 DEPTH=4, delay=63, five requests -> req_ready low with 4 pending until first burst pops.
REQ-040 Reset at 2nd rw_rdy cycle -> rw_rdy 0 next cycle, FIFO empty, req_ready 1 after release, no stale burst.
REQ-041 SCHED_STATS_EN defined, 3 READs + 2 WRITEs -> act_cnt=5, rd_cnt=3, wr_cnt=2; undefined -> all 0.
